branch_predict_ctrl: RTL and testbench

//  Sequences control flow around the Branch/PC_Branch datapath. Holds a table of
//  2-bit saturating counters, predicts conditional branches in ID, redirects for

---
 rtl/branch_predict_ctrl.sv | 151 +++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl
//   Branch prediction and redirect controller for the Branch/PC_Branch datapath.
//   A table of 2-bit saturating counters, indexed by pc[IDX_W+1:2], predicts
//   conditional branches in ID. Jumps and predicted-taken branches in ID request
//   a redirect. A branch that resolves in EX against its prediction flushes the
//   younger stages. Every redirect PC is handed to fetch over redir_valid/redir_ready.
//
//   Ports
//     clk, rst_n                    clock (rising edge), async active-low reset
//     stall                         freezes ID-side redirect requests and table updates
//     id_valid/id_is_br/id_is_jmp   ID instruction qualifiers
//     id_pc/id_br_target/id_j_addr  ID PC and its candidate targets
//     pred_taken                    combinational prediction for the ID instruction
//     ex_valid/ex_is_br/ex_pc       EX branch resolution inputs
//     ex_pred_taken/ex_taken        carried prediction and actual outcome
//     ex_br_target                  taken target of the EX branch
//     flush_id/flush_ex             one-cycle squash pulses for IF/ID and ID/EX
//     redir_valid/redir_pc          redirect request to fetch
//     redir_ready                   fetch accepts the redirect
//
//   Optional feature (macro BRANCH_STATS_EN):
//     stat_branches, stat_mispred   32-bit counts of resolved branches and
//                                   mispredictions; not counted while stalled.
//
//   state | meaning
//   IDLE  | no redirect pending
//   REQ   | redir_valid high, waiting for redir_ready
module branch_predict_ctrl #(
   parameter int         IDX_W    = 6,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        id_valid,
   input  logic        id_is_br,
   input  logic        id_is_jmp,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_br_target,
   input  logic [31:0] id_j_addr,
   output logic        pred_taken,
   input  logic        ex_valid,
   input  logic        ex_is_br,
   input  logic [31:0] ex_pc,
   input  logic        ex_pred_taken,
   input  logic        ex_taken,
   input  logic [31:0] ex_br_target,
   output logic        flush_id,
   output logic        flush_ex,
   output logic        redir_valid,
   output logic [31:0] redir_pc,
   input  logic        redir_ready
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred
`endif
);

   localparam int N = 1 << IDX_W;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [1:0]        bht [N];
   logic [IDX_W-1:0]  id_idx, ex_idx;
   logic              misp, idrd, upd, load;
   logic [31:0]       tgt;
   logic              unused_bits;

   assign id_idx = id_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign unused_bits = ^{id_pc[31:IDX_W+2], id_pc[1:0]};

   // Table read is the registered value: a same-cycle update is not bypassed.
   assign pred_taken = bht[id_idx][1] & id_is_br & id_valid;

   assign misp = ex_valid & ex_is_br & (ex_taken != ex_pred_taken);
   assign idrd = ~stall & id_valid & (id_is_jmp | pred_taken);
   assign upd  = ex_valid & ex_is_br & ~stall;

   // MISP is always accepted; an ID redirect only when nothing is pending,
   // because while a redirect waits the ID slot is stale.
   assign load = misp | (idrd & (state == IDLE));

   always_comb begin
      tgt = id_is_jmp ? id_j_addr : id_br_target;
      if (misp)
         tgt = ex_taken ? ex_br_target : ex_pc + 32'd4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (load) state_nxt = REQ;
         REQ:  if (!misp && redir_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      redir_valid = (state == REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redir_pc <= 32'd0;
         flush_id <= 1'b0;
         flush_ex <= 1'b0;
      end else begin
         flush_id <= load;
         flush_ex <= misp;
         if (load)
            redir_pc <= tgt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++)
            bht[i] <= CNT_INIT;
      end else if (upd) begin
         if (ex_taken && bht[ex_idx] != 2'b11)
            bht[ex_idx] <= bht[ex_idx] + 2'd1;
         else if (!ex_taken && bht[ex_idx] != 2'b00)
            bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches <= 32'd0;
         stat_mispred  <= 32'd0;
      end else begin
         if (upd)
            stat_branches <= stat_branches + 32'd1;
         if (misp && !stall)
            stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, id_valid, id_is_br, id_is_jmp;
   logic [31:0] id_pc, id_br_target, id_j_addr;
   logic        pred_taken;
   logic        ex_valid, ex_is_br, ex_pred_taken, ex_taken;
   logic [31:0] ex_pc, ex_br_target;
   logic        flush_id, flush_ex, redir_valid, redir_ready;
   logic [31:0] redir_pc;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches, stat_mispred;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   // reference model
   int          m_cnt [64];
   bit          m_valid, m_fid, m_fex;
   logic [31:0] m_pc;
   int unsigned m_sb, m_sm;

   always #5 clk = ~clk;

   branch_predict_ctrl dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .id_valid(id_valid), .id_is_br(id_is_br), .id_is_jmp(id_is_jmp),
      .id_pc(id_pc), .id_br_target(id_br_target), .id_j_addr(id_j_addr),
      .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc),
      .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken), .ex_br_target(ex_br_target),
      .flush_id(flush_id), .flush_ex(flush_ex),
      .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready)
`ifdef BRANCH_STATS_EN
      , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
   );

   function automatic int pc_idx(input logic [31:0] pc);
      return int'((pc >> 2) & 32'd63);
   endfunction

   function automatic bit model_pred();
      return id_valid && id_is_br && (m_cnt[pc_idx(id_pc)] >= 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_cnt[i] = 1;
      m_valid = 0; m_fid = 0; m_fex = 0; m_pc = 32'd0; m_sb = 0; m_sm = 0;
   endtask

   task automatic clear_inputs();
      stall = 0; id_valid = 0; id_is_br = 0; id_is_jmp = 0;
      id_pc = 0; id_br_target = 0; id_j_addr = 0;
      ex_valid = 0; ex_is_br = 0; ex_pc = 0; ex_pred_taken = 0; ex_taken = 0;
      ex_br_target = 0; redir_ready = 0;
   endtask

   // Advance one clock and update the model from the inputs held before the edge.
   task automatic tick();
      bit misp, idrd, br;
      int e;
      misp = ex_valid && ex_is_br && (ex_taken != ex_pred_taken);
      idrd = !stall && id_valid && (id_is_jmp || model_pred());
      br   = ex_valid && ex_is_br && !stall;
      e    = pc_idx(ex_pc);
      @(posedge clk); #1;
      if (misp) begin
         m_pc = ex_taken ? ex_br_target : ex_pc + 32'd4;
         m_valid = 1; m_fid = 1; m_fex = 1;
      end else if (idrd && !m_valid) begin
         m_pc = id_is_jmp ? id_j_addr : id_br_target;
         m_valid = 1; m_fid = 1; m_fex = 0;
      end else begin
         m_fid = 0; m_fex = 0;
         if (m_valid && redir_ready) m_valid = 0;
      end
      if (br) begin
         m_cnt[e] = ex_taken ? ((m_cnt[e] == 3) ? 3 : m_cnt[e] + 1)
                             : ((m_cnt[e] == 0) ? 0 : m_cnt[e] - 1);
         m_sb++;
         if (misp) m_sm++;
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      #12;
      model_reset();
      rst_n = 1;
      tick();
      total_cnt++; if (redir_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", redir_valid); else pass_cnt++;
      total_cnt++; if (redir_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", redir_pc); else pass_cnt++;
      total_cnt++; if ({flush_id, flush_ex} !== 2'b00) $display("FAIL reset_flush got %b want 00", {flush_id, flush_ex}); else pass_cnt++;
      stall = 1; id_valid = 1; id_is_br = 1; id_pc = 32'h40; #1;
      total_cnt++; if (pred_taken !== 1'b0) $display("FAIL reset_pred got %0b want 0", pred_taken); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_misp_basic();
      ex_valid = 1; ex_is_br = 1; ex_pc = 32'h40; ex_taken = 1; ex_pred_taken = 0;
      ex_br_target = 32'h80;
      tick();
      total_cnt++; if (redir_valid !== 1'b1) $display("FAIL misp_valid got %0b want 1", redir_valid); else pass_cnt++;
      total_cnt++; if (redir_pc !== 32'h80) $display("FAIL misp_pc got %h want 00000080", redir_pc); else pass_cnt++;
      total_cnt++; if ({flush_id, flush_ex} !== 2'b11) $display("FAIL misp_flush got %b want 11", {flush_id, flush_ex}); else pass_cnt++;
      clear_inputs();
      tick();
      total_cnt++; if ({flush_id, flush_ex} !== 2'b00) $display("FAIL misp_pulse got %b want 00", {flush_id, flush_ex}); else pass_cnt++;
      total_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h80) $display("FAIL misp_hold got %0b/%h want 1/00000080", redir_valid, redir_pc); else pass_cnt++;
      redir_ready = 1;
      tick();
      total_cnt++; if (redir_valid !== 1'b0) $display("FAIL misp_accept got %0b want 0", redir_valid); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_pred_redirect();
      id_valid = 1; id_is_br = 1; id_pc = 32'h40; id_br_target = 32'h1234_5670; #1;
      total_cnt++; if (pred_taken !== 1'b1) $display("FAIL pred_trained got %0b want 1", pred_taken); else pass_cnt++;
      tick();
      total_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h1234_5670) $display("FAIL pred_redir got %0b/%h want 1/12345670", redir_valid, redir_pc); else pass_cnt++;
      total_cnt++; if ({flush_id, flush_ex} !== 2'b10) $display("FAIL pred_flush got %b want 10", {flush_id, flush_ex}); else pass_cnt++;
      clear_inputs(); redir_ready = 1;
      tick();
      clear_inputs();
   endtask

   task automatic test_jump_hold();
      id_valid = 1; id_is_jmp = 1; id_j_addr = 32'h0040_0100;
      tick();
      clear_inputs();
      for (int c = 0; c < 3; c++) begin
         total_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h0040_0100) $display("FAIL jmp_hold%0d got %0b/%h want 1/00400100", c, redir_valid, redir_pc); else pass_cnt++;
         if (c < 2) tick();
      end
      redir_ready = 1;
      tick();
      total_cnt++; if (redir_valid !== 1'b0) $display("FAIL jmp_release got %0b want 0", redir_valid); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_priority();
      id_valid = 1; id_is_jmp = 1; id_j_addr = 32'h0040_0100;
      ex_valid = 1; ex_is_br = 1; ex_pc = 32'h100; ex_taken = 0; ex_pred_taken = 1;
      ex_br_target = 32'h300;
      tick();
      total_cnt++; if (redir_pc !== 32'h104) $display("FAIL prio_pc got %h want 00000104", redir_pc); else pass_cnt++;
      total_cnt++; if ({flush_id, flush_ex} !== 2'b11) $display("FAIL prio_flush got %b want 11", {flush_id, flush_ex}); else pass_cnt++;
      clear_inputs(); redir_ready = 1;
      tick();
      total_cnt++; if (redir_valid !== 1'b0) $display("FAIL prio_drop got %0b want 0", redir_valid); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_saturation();
      redir_ready = 1;
      ex_valid = 1; ex_is_br = 1; ex_pc = 32'h280; ex_taken = 1; ex_pred_taken = 1;
      repeat (5) tick();
      ex_taken = 0; ex_pred_taken = 0;
      tick();
      ex_valid = 0; stall = 1; id_valid = 1; id_is_br = 1; id_pc = 32'h280; #1;
      total_cnt++; if (pred_taken !== 1'b1) $display("FAIL sat_high got %0b want 1", pred_taken); else pass_cnt++;
      stall = 0; id_valid = 0; ex_valid = 1;
      repeat (5) tick();
      ex_taken = 1; ex_pred_taken = 1;
      tick();
      ex_valid = 0; stall = 1; id_valid = 1; #1;
      total_cnt++; if (pred_taken !== 1'b0) $display("FAIL sat_low got %0b want 0", pred_taken); else pass_cnt++;
      total_cnt++; if (redir_valid !== 1'b0) $display("FAIL sat_noredir got %0b want 0", redir_valid); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_wrap();
      redir_ready = 1;
      ex_valid = 1; ex_is_br = 1; ex_pc = 32'hFFFF_FFFC; ex_taken = 0; ex_pred_taken = 1;
      tick();
      total_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h0) $display("FAIL wrap_pc got %0b/%h want 1/00000000", redir_valid, redir_pc); else pass_cnt++;
      clear_inputs(); redir_ready = 1;
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         stall         = ($urandom_range(0, 4) == 0);
         id_valid      = ($urandom_range(0, 3) != 0);
         id_is_br      = $urandom_range(0, 1);
         id_is_jmp     = !id_is_br && ($urandom_range(0, 3) == 0);
         id_pc         = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
         id_br_target  = $urandom;
         id_j_addr     = $urandom;
         ex_valid      = ($urandom_range(0, 3) != 0);
         ex_is_br      = ($urandom_range(0, 3) != 0);
         ex_pc         = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
         ex_taken      = $urandom_range(0, 1);
         ex_pred_taken = ($urandom_range(0, 2) == 0) ? !ex_taken : ex_taken;
         ex_br_target  = $urandom;
         redir_ready   = $urandom_range(0, 1);
         #1;
         total_cnt++; if (pred_taken !== model_pred()) $display("FAIL rnd_pred[%0d] got %0b want %0b", n, pred_taken, model_pred()); else pass_cnt++;
         tick();
         total_cnt++;
         if (redir_valid !== m_valid || flush_id !== m_fid || flush_ex !== m_fex || (m_valid && redir_pc !== m_pc))
            $display("FAIL rnd_out[%0d] got v%0b fi%0b fe%0b pc %h want v%0b fi%0b fe%0b pc %h",
                     n, redir_valid, flush_id, flush_ex, redir_pc, m_valid, m_fid, m_fex, m_pc);
         else pass_cnt++;
`ifdef BRANCH_STATS_EN
         total_cnt++; if (stat_branches !== m_sb || stat_mispred !== m_sm) $display("FAIL rnd_stats[%0d] got %0d/%0d want %0d/%0d", n, stat_branches, stat_mispred, m_sb, m_sm); else pass_cnt++;
`endif
      end
      clear_inputs(); redir_ready = 1;
      tick(); tick();
      clear_inputs();
   endtask

   task automatic test_async_reset();
      id_valid = 1; id_is_jmp = 1; id_j_addr = 32'hDEAD_BEE0;
      tick();
      clear_inputs();
      total_cnt++; if (redir_valid !== 1'b1) $display("FAIL arst_setup got %0b want 1", redir_valid); else pass_cnt++;
      #2 rst_n = 0;
      #1;
      total_cnt++; if (redir_valid !== 1'b0 || redir_pc !== 32'h0) $display("FAIL arst_drop got %0b/%h want 0/00000000", redir_valid, redir_pc); else pass_cnt++;
      stall = 1; id_valid = 1; id_is_br = 1; id_pc = 32'h40; #1;
      total_cnt++; if (pred_taken !== 1'b0) $display("FAIL arst_table got %0b want 0", pred_taken); else pass_cnt++;
`ifdef BRANCH_STATS_EN
      total_cnt++; if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) $display("FAIL arst_stats got %0d/%0d want 0/0", stat_branches, stat_mispred); else pass_cnt++;
`endif
      clear_inputs();
      #3 rst_n = 1;
      model_reset();
      redir_ready = 1;
      ex_valid = 1; ex_is_br = 1; ex_pc = 32'h40; ex_taken = 1; ex_pred_taken = 1;
      tick();
      clear_inputs();
      stall = 1; id_valid = 1; id_is_br = 1; id_pc = 32'h40; #1;
      total_cnt++; if (pred_taken !== 1'b1) $display("FAIL arst_init got %0b want 1", pred_taken); else pass_cnt++;
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_misp_basic();
      test_pred_redirect();
      test_jump_hold();
      test_priority();
      test_saturation();
      test_wrap();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
